// File: rtl/tqvp_stevej_patter_pkg.sv
// Shared definitions for the watchdog patter peripheral.
//   - register addresses (6-bit TinyQV peripheral address space)
//   - FSM state encoding
//   - STATUS register bit positions (read fields and write-1-to-clear bits)
package tqvp_stevej_patter_pkg;

  localparam logic [5:0] ADDR_CTRL    = 6'h0;
  localparam logic [5:0] ADDR_PERIOD  = 6'h1;
  localparam logic [5:0] ADDR_WIDTH   = 6'h2;
  localparam logic [5:0] ADDR_TIMEOUT = 6'h3;
  localparam logic [5:0] ADDR_STATUS  = 6'h4;
  localparam logic [5:0] ADDR_KICK    = 6'h5;
  localparam logic [5:0] ADDR_UI      = 6'h6;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    WAIT     = 2'd1,
    PULSE    = 2'd2,
    ACKWAIT  = 2'd3
  } state_t;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_FAULT     = 1;
  localparam int unsigned STAT_MISS_LSB  = 8;
  localparam int unsigned STAT_PCNT_LSB  = 16;
  localparam int unsigned STAT_CLR_FAULT = 1;
  localparam int unsigned STAT_CLR_MISS  = 2;

endpackage

// File: rtl/tqvp_stevej_patter_core.sv
// Pat sequencer: FSM with a shared 32-bit cycle counter, ack rising-edge
// detector, fault latch, saturating miss counter and wrapping pulse counter.
// Ports:
//   clk, rst                      clock, async active-high reset
//   enable                        run request (0 forces DISABLED)
//   period, width, timeout        timing configuration
//   kick                          one-cycle immediate pulse request
//   ack, expired                  synchronised watchdog lines
//   clr_fault, clr_miss           one-cycle clear requests
//   state, fault, miss_cnt, pulse_cnt  status outputs
//
// state    | meaning
// DISABLED | idle, pat low, cnt held at 0
// WAIT     | idle gap before next pat pulse (KICK shortcuts it)
// PULSE    | pat high for max(WIDTH,1) cycles
// ACKWAIT  | waiting up to TIMEOUT cycles for the ack rising edge
module tqvp_stevej_patter_core
  import tqvp_stevej_patter_pkg::*;
#(
  parameter int MISS_W = 8,
  parameter int PCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [31:0]       period,
  input  logic [7:0]        width,
  input  logic [15:0]       timeout,
  input  logic              kick,
  input  logic              ack,
  input  logic              expired,
  input  logic              clr_fault,
  input  logic              clr_miss,
  output state_t            state,
  output logic              fault,
  output logic [MISS_W-1:0] miss_cnt,
  output logic [PCNT_W-1:0] pulse_cnt
);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        ack_prev;
  logic        ack_rise;
  logic        pulse_done;
  logic        miss;
  logic [31:0] period_last, width_last, timeout_last;

  // Zero values for PERIOD/WIDTH behave as 1.
  assign period_last  = (period == 32'd0) ? 32'd0 : period - 32'd1;
  assign width_last   = (width == 8'd0) ? 32'd0 : {24'd0, width} - 32'd1;
  assign timeout_last = {16'd0, timeout} - 32'd1;
  assign ack_rise     = ack & ~ack_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DISABLED;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 32'd1;
    pulse_done = 1'b0;
    miss       = 1'b0;
    if (!enable) begin
      state_d = DISABLED;
      cnt_d   = 32'd0;
    end else begin
      case (state_q)
        DISABLED: begin
          state_d = WAIT;
          cnt_d   = 32'd0;
        end
        WAIT: begin
          if (kick || cnt_q == period_last) begin
            state_d = PULSE;
            cnt_d   = 32'd0;
          end
        end
        PULSE: begin
          if (cnt_q == width_last) begin
            state_d    = (timeout == 16'd0) ? WAIT : ACKWAIT;
            cnt_d      = 32'd0;
            pulse_done = 1'b1;
          end
        end
        ACKWAIT: begin
          // An ack on the final timeout cycle still counts as acked.
          if (ack_rise) begin
            state_d = WAIT;
            cnt_d   = 32'd0;
          end else if (cnt_q == timeout_last) begin
            state_d = WAIT;
            cnt_d   = 32'd0;
            miss    = 1'b1;
          end
        end
        default: begin
          state_d = DISABLED;
          cnt_d   = 32'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_prev  <= 1'b0;
      fault     <= 1'b0;
      miss_cnt  <= '0;
      pulse_cnt <= '0;
    end else begin
      ack_prev <= ack;
      // Set takes priority over a same-cycle clear.
      if (miss || (expired && state_q != DISABLED)) fault <= 1'b1;
      else if (clr_fault)                          fault <= 1'b0;
      if (miss) begin
        if (clr_miss)              miss_cnt <= {{(MISS_W-1){1'b0}}, 1'b1};
        else if (miss_cnt != '1)   miss_cnt <= miss_cnt + 1'b1;
      end else if (clr_miss) begin
        miss_cnt <= '0;
      end
      if (pulse_done) pulse_cnt <= pulse_cnt + 1'b1;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/tqvp_stevej_watchdog_patter.sv
// TinyQV peripheral top: register file, read mux and PMOD output mapping
// around the pat sequencer core.
// Ports:
//   clk, rst        clock, async active-high reset
//   ui_in           input PMOD ([0]=ack, [1]=watchdog expired)
//   uo_out          output PMOD ([2]=pat, [3]=enable, [4]=fault,
//                   [5]=ack wait, [6]=~pat, others 0)
//   address, data_in, data_write_n, data_read_n  bus interface
//   data_out, data_ready                         read data, always ready
//   user_interrupt  fault & irq_en
module tqvp_stevej_watchdog_patter
  import tqvp_stevej_patter_pkg::*;
#(
  parameter int MISS_W = 8,
  parameter int PCNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  logic              enable, irq_en;
  logic [31:0]       period;
  logic [7:0]        width;
  logic [15:0]       timeout;
  logic              wr, kick, clr_fault, clr_miss;
  state_t            state;
  logic              fault, pat;
  logic [MISS_W-1:0] miss_cnt;
  logic [PCNT_W-1:0] pulse_cnt;
  logic [31:0]       status;
  logic              unused_ok;

  assign wr        = (data_write_n != 2'b11);
  assign kick      = wr && (address == ADDR_KICK);
  assign clr_fault = wr && (address == ADDR_STATUS) && data_in[STAT_CLR_FAULT];
  assign clr_miss  = wr && (address == ADDR_STATUS) && data_in[STAT_CLR_MISS];

  // Timing registers are frozen while running so the FSM compares never
  // see a moving target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable  <= 1'b0;
      irq_en  <= 1'b0;
      period  <= 32'd0;
      width   <= 8'd0;
      timeout <= 16'd0;
    end else if (wr) begin
      case (address)
        ADDR_CTRL: begin
          enable <= data_in[0];
          irq_en <= data_in[1];
        end
        ADDR_PERIOD:  if (!enable) period  <= data_in;
        ADDR_WIDTH:   if (!enable) width   <= data_in[7:0];
        ADDR_TIMEOUT: if (!enable) timeout <= data_in[15:0];
        default: ;
      endcase
    end
  end

  tqvp_stevej_patter_core #(
    .MISS_W(MISS_W),
    .PCNT_W(PCNT_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .period    (period),
    .width     (width),
    .timeout   (timeout),
    .kick      (kick),
    .ack       (ui_in[0]),
    .expired   (ui_in[1]),
    .clr_fault (clr_fault),
    .clr_miss  (clr_miss),
    .state     (state),
    .fault     (fault),
    .miss_cnt  (miss_cnt),
    .pulse_cnt (pulse_cnt)
  );

  assign pat = (state == PULSE);

  always_comb begin
    status                            = 32'd0;
    status[STAT_BUSY]                 = (state != DISABLED);
    status[STAT_FAULT]                = fault;
    status[STAT_MISS_LSB +: MISS_W]   = miss_cnt;
    status[STAT_PCNT_LSB +: PCNT_W]   = pulse_cnt;
  end

  always_comb begin
    data_out = 32'd0;
    case (address)
      ADDR_CTRL:    data_out = {30'd0, irq_en, enable};
      ADDR_PERIOD:  data_out = period;
      ADDR_WIDTH:   data_out = {24'd0, width};
      ADDR_TIMEOUT: data_out = {16'd0, timeout};
      ADDR_STATUS:  data_out = status;
      ADDR_UI:      data_out = {24'd0, ui_in};
      default:      data_out = 32'd0;
    endcase
  end

  assign uo_out         = {1'b0, ~pat, (state == ACKWAIT), fault, enable, pat, 2'b00};
  assign data_ready     = 1'b1;
  assign user_interrupt = fault & irq_en;
  assign unused_ok      = &{1'b0, data_read_n};

endmodule

// File: tb/tb_tqvp_stevej_watchdog_patter.sv
module tb_tqvp_stevej_watchdog_patter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  int checks = 0;
  int errors = 0;

  tqvp_stevej_watchdog_patter dut (
    .clk            (clk),
    .rst            (rst),
    .ui_in          (ui_in),
    .uo_out         (uo_out),
    .address        (address),
    .data_in        (data_in),
    .data_write_n   (data_write_n),
    .data_read_n    (data_read_n),
    .data_out       (data_out),
    .data_ready     (data_ready),
    .user_interrupt (user_interrupt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [5:0] a, input logic [31:0] d);
    address      = a;
    data_in      = d;
    data_write_n = 2'b10;
    tick();
    data_write_n = 2'b11;
    data_in      = 32'd0;
  endtask

  task automatic read_reg(input logic [5:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = data_out;
  endtask

  task automatic wait_pat(input logic lvl, output int n);
    n = 0;
    while (uo_out[2] !== lvl && n < 3000) begin
      tick();
      n++;
    end
    if (uo_out[2] !== lvl) check("wait_pat_timeout", {31'd0, uo_out[2]}, {31'd0, lvl});
  endtask

  task automatic wait_ackwait_end();
    int n;
    n = 0;
    while (uo_out[5] !== 1'b0 && n < 3000) begin
      tick();
      n++;
    end
    if (uo_out[5] !== 1'b0) check("ackwait_timeout", {31'd0, uo_out[5]}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int n;
    rst = 1'b1; ui_in = 8'h00; address = 6'h0; data_in = 32'd0;
    data_write_n = 2'b11; data_read_n = 2'b11;
    #1;
    check("rst_uo_out", {24'd0, uo_out}, 32'h40);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    read_reg(6'h4, rd);
    check("rst_status", rd, 32'h0);
    check("data_ready", {31'd0, data_ready}, 32'd1);
    check("rst_irq", {31'd0, user_interrupt}, 32'd0);

    // expiry while disabled is ignored; UI readback
    ui_in = 8'h02; tick(); ui_in = 8'h00; tick();
    read_reg(6'h4, rd);
    check("expired_disabled", rd, 32'h0);
    ui_in = 8'hA4;
    read_reg(6'h6, rd);
    check("ui_read", rd, 32'h0000_00A4);
    ui_in = 8'h00;

    // normal cycle
    write_reg(6'h1, 32'd10);
    write_reg(6'h2, 32'd3);
    write_reg(6'h3, 32'd0);
    write_reg(6'h0, 32'd1);
    wait_pat(1'b1, n);
    check("first_rise_lat", n, 32'd11);
    check("uo_pulse", {24'd0, uo_out}, 32'h0C);
    wait_pat(1'b0, n);
    check("width1", n, 32'd3);
    check("uo_wait", {24'd0, uo_out}, 32'h48);
    wait_pat(1'b1, n);
    check("gap", n, 32'd10);
    wait_pat(1'b0, n);
    check("width2", n, 32'd3);
    read_reg(6'h4, rd);
    check("status_2pulses", rd, 32'h0002_0001);

    // ack path, TIMEOUT=5
    write_reg(6'h0, 32'd0);
    write_reg(6'h3, 32'd5);
    write_reg(6'h0, 32'd1);
    wait_pat(1'b1, n);
    wait_pat(1'b0, n);
    check("uo_ackwait", {24'd0, uo_out}, 32'h68);
    repeat (2) tick();
    ui_in = 8'h01; tick();
    check("ack_early", {24'd0, uo_out}, 32'h48);
    ui_in = 8'h00;
    wait_pat(1'b1, n);
    wait_pat(1'b0, n);
    repeat (4) tick();
    ui_in = 8'h01; tick();
    check("ack_last_cycle", {24'd0, uo_out}, 32'h48);
    ui_in = 8'h00;
    read_reg(6'h4, rd);
    check("status_acked", rd, 32'h0004_0001);

    // miss path, TIMEOUT=4, irq enabled
    write_reg(6'h0, 32'd0);
    write_reg(6'h3, 32'd4);
    write_reg(6'h0, 32'd3);
    for (int i = 0; i < 3; i++) begin
      wait_pat(1'b1, n);
      wait_pat(1'b0, n);
    end
    wait_ackwait_end();
    read_reg(6'h4, rd);
    check("status_3miss", rd, 32'h0007_0303);
    check("irq_set", {31'd0, user_interrupt}, 32'd1);
    check("uo_fault", {24'd0, uo_out}, 32'h58);
    write_reg(6'h4, 32'h2);
    check("irq_cleared", {31'd0, user_interrupt}, 32'd0);
    read_reg(6'h4, rd);
    check("miss_kept", rd, 32'h0007_0301);
    write_reg(6'h0, 32'd0);
    tick();
    read_reg(6'h4, rd);
    check("disabled_retain", rd, 32'h0007_0300);

    // saturation: PERIOD=WIDTH=TIMEOUT=1, one miss every 3 cycles
    write_reg(6'h4, 32'h6);
    write_reg(6'h1, 32'd1);
    write_reg(6'h2, 32'd1);
    write_reg(6'h3, 32'd1);
    write_reg(6'h0, 32'd1);
    repeat (31) tick();
    read_reg(6'h4, rd);
    check("miss_10", rd, 32'h0011_0A03);
    repeat (900) tick();
    read_reg(6'h4, rd);
    check("miss_sat", {24'd0, rd[15:8]}, 32'd255);
    write_reg(6'h0, 32'd0);
    tick();

    // config lock and kick
    write_reg(6'h4, 32'h6);
    write_reg(6'h1, 32'd1000);
    write_reg(6'h2, 32'd3);
    write_reg(6'h3, 32'd0);
    write_reg(6'h0, 32'd1);
    write_reg(6'h1, 32'd5);
    read_reg(6'h1, rd);
    check("period_locked", rd, 32'd1000);
    repeat (3) tick();
    check("pat_before_kick", {31'd0, uo_out[2]}, 32'd0);
    write_reg(6'h5, 32'd1);
    check("kick_pat", {31'd0, uo_out[2]}, 32'd1);
    write_reg(6'h5, 32'd1);
    check("kick_pulse_1", {31'd0, uo_out[2]}, 32'd1);
    tick();
    check("kick_pulse_2", {31'd0, uo_out[2]}, 32'd1);
    tick();
    check("kick_pulse_end", {31'd0, uo_out[2]}, 32'd0);
    repeat (5) tick();
    check("kick_no_retrig", {31'd0, uo_out[2]}, 32'd0);
    read_reg(6'h5, rd);
    check("kick_read", rd, 32'd0);
    ui_in = 8'h02; tick(); ui_in = 8'h00;
    read_reg(6'h4, rd);
    check("expired_fault", {30'd0, rd[1:0]}, 32'd3);

    // async reset mid-pulse
    write_reg(6'h5, 32'd1);
    check("pre_rst_pat", {31'd0, uo_out[2]}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_uo", {24'd0, uo_out}, 32'h40);
    read_reg(6'h4, rd);
    check("async_rst_status", rd, 32'h0);
    read_reg(6'h0, rd);
    check("async_rst_ctrl", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
